// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART, 16x oversampled RX with
// 3-sample majority vote, valid/ready TX and per-frame error flags.
module uart_cfg #(
  parameter int sys_clk_freq = 12000000,
  parameter int baud_rate    = 9600,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 is_receiving,
  output logic                 is_transmitting
);
  localparam int DIV = sys_clk_freq / (baud_rate * 16);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  tx_state_e tx_state_q, tx_state_d;
  logic [DW-1:0] tx_div_q, tx_div_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shr_q, tx_shr_d;
  logic tx_par_q, tx_par_d;
  logic tx_q, tx_d;
  logic tx_tick, tx_end;

  rx_state_e rx_state_q, rx_state_d;
  logic rx_s1_q, rx_s2_q;
  logic [DW-1:0] rx_div_q, rx_div_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_idx_q, rx_idx_d;
  logic [1:0] rx_ones_q, rx_ones_d, rx_ones_sum;
  logic [DATA_BITS-1:0] rx_shr_q, rx_shr_d;
  logic rx_perr_q, rx_perr_d;
  logic rx_armed_q, rx_armed_d;
  logic rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic perr_q, perr_d, ferr_q, ferr_d;
  logic rx_tick, rx_samp, rx_dec, rx_end, rx_maj;

  assign tx_tick = (tx_div_q == DIV_M1);
  assign tx_end = tx_tick && (tx_cnt_q == 4'd15);
  // ready on the final stop clock allows gapless back-to-back frames
  assign tx_ready = (tx_state_q == TX_IDLE) ||
    ((tx_state_q == TX_STOP) && tx_end && (tx_idx_q == LAST_S));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
    tx_cnt_d = tx_tick ? tx_cnt_q + 4'd1 : tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_shr_d = tx_shr_q;
    tx_par_d = tx_par_q;
    tx_d = 1'b1;
    unique case (tx_state_q)
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_shr_d = tx_shr_q >> 1;
        tx_idx_d = tx_idx_q + 4'd1;
        if (tx_idx_q == LAST_D) begin
          tx_idx_d = '0;
          tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_state_d = TX_STOP;
        tx_idx_d = '0;
      end
      TX_STOP: if (tx_end) begin
        tx_idx_d = tx_idx_q + 4'd1;
        if (tx_idx_q == LAST_S) tx_state_d = TX_IDLE;
      end
      default: ;
    endcase
    if (tx_valid && tx_ready) begin
      tx_state_d = TX_START;
      tx_shr_d = tx_data;
      tx_par_d = par_of(tx_data);
      tx_div_d = '0;
      tx_cnt_d = '0;
      tx_idx_d = '0;
    end
    unique case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA: tx_d = tx_shr_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign rx_tick = (rx_div_q == DIV_M1);
  assign rx_samp = rx_tick && (rx_cnt_q >= 4'd7) && (rx_cnt_q <= 4'd9);
  assign rx_dec = rx_tick && (rx_cnt_q == 4'd9);
  assign rx_end = rx_tick && (rx_cnt_q == 4'd15);
  assign rx_ones_sum = rx_ones_q + {1'b0, rx_s2_q};
  assign rx_maj = rx_ones_sum[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_cnt_d = rx_tick ? rx_cnt_q + 4'd1 : rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_ones_d = rx_ones_q;
    rx_shr_d = rx_shr_q;
    rx_perr_d = rx_perr_q;
    rx_armed_d = rx_armed_q | rx_s2_q;
    rx_valid_d = 1'b0;
    rx_data_d = rx_data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    if (rx_samp) rx_ones_d = rx_dec ? 2'd0 : rx_ones_sum;
    unique case (rx_state_q)
      RX_IDLE: if (rx_armed_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_div_d = '0;
        rx_cnt_d = '0;
        rx_ones_d = '0;
        rx_perr_d = 1'b0;
      end
      RX_START: begin
        if (rx_dec && rx_maj) rx_state_d = RX_IDLE;
        else if (rx_end) begin
          rx_state_d = RX_DATA;
          rx_idx_d = '0;
        end
      end
      RX_DATA: begin
        if (rx_dec) rx_shr_d = {rx_maj, rx_shr_q[DATA_BITS-1:1]};
        if (rx_end) begin
          rx_idx_d = rx_idx_q + 4'd1;
          if (rx_idx_q == LAST_D)
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_dec) rx_perr_d = rx_maj ^ par_of(rx_shr_q);
        if (rx_end) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_dec) begin
        rx_state_d = RX_IDLE;
        rx_valid_d = 1'b1;
        rx_data_d = rx_shr_q;
        perr_d = (PARITY != 0) && rx_perr_q;
        ferr_d = !rx_maj;
        // a low stop bit must see the line high again before re-arming
        rx_armed_d = rx_maj;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q <= '0;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_shr_q <= '0;
      tx_par_q <= 1'b0;
      tx_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_div_q <= '0;
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_ones_q <= '0;
      rx_shr_q <= '0;
      rx_perr_q <= 1'b0;
      rx_armed_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q <= tx_div_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_shr_q <= tx_shr_d;
      tx_par_q <= tx_par_d;
      tx_q <= tx_d;
      rx_state_q <= rx_state_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_div_q <= rx_div_d;
      rx_cnt_q <= rx_cnt_d;
      rx_idx_q <= rx_idx_d;
      rx_ones_q <= rx_ones_d;
      rx_shr_q <= rx_shr_d;
      rx_perr_q <= rx_perr_d;
      rx_armed_q <= rx_armed_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end

  assign tx = tx_q;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
  assign parity_error = perr_q;
  assign framing_error = ferr_q;
  assign is_receiving = (rx_state_q != RX_IDLE);
  assign is_transmitting = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: scoreboard bench for uart_cfg in 8N1 (loopback),
// 7E2 (loopback) and 8O1 (bench-driven line) configurations.
module tb_uart_cfg;
  logic clk, rst;
  logic loop_a, rx_drv_a, rx_drv_c;
  logic rx_a, tx_a, tx_valid_a, tx_ready_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic rx_valid_a, pe_a, fe_a, is_rx_a, is_tx_a;
  logic rx_b, tx_b, tx_valid_b, tx_ready_b;
  logic [6:0] tx_data_b, rx_data_b;
  logic rx_valid_b, pe_b, fe_b, is_rx_b, is_tx_b;
  logic rx_c, tx_c, tx_ready_c, tx_valid_c;
  logic [7:0] tx_data_c, rx_data_c;
  logic rx_valid_c, pe_c, fe_c, is_rx_c, is_tx_c;
  logic started;
  int n_chk, n_fail, cyc;

  typedef struct { logic [8:0] d; logic pe; logic fe; } exp_t;
  exp_t rxq_a[$], rxq_b[$], rxq_c[$];
  logic line_a[$], line_b[$];
  int hs_a[$], hs_b[$];

  assign rx_a = loop_a ? tx_a : rx_drv_a;
  assign rx_b = tx_b;
  assign rx_c = rx_drv_c;

  uart_cfg #(.sys_clk_freq(1600000), .baud_rate(100000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .parity_error(pe_a), .framing_error(fe_a),
    .is_receiving(is_rx_a), .is_transmitting(is_tx_a));

  uart_cfg #(.sys_clk_freq(1600000), .baud_rate(100000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .parity_error(pe_b), .framing_error(fe_b),
    .is_receiving(is_rx_b), .is_transmitting(is_tx_b));

  uart_cfg #(.sys_clk_freq(1600000), .baud_rate(100000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .tx(tx_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_data(tx_data_c),
    .rx_valid(rx_valid_c), .rx_data(rx_data_c),
    .parity_error(pe_c), .framing_error(fe_c),
    .is_receiving(is_rx_c), .is_transmitting(is_tx_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Line image of one frame, one entry per bit, start bit first.
  function automatic int frame_bits(input int d, input int dbits,
      input int par, input int stops, output logic [15:0] b);
    int n;
    logic p;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      b[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par == 1) begin b[n] = ~p; n++; end
    else if (par == 2) begin b[n] = p; n++; end
    for (int i = 0; i < stops; i++) begin b[n] = 1'b1; n++; end
    return n;
  endfunction

  always @(negedge clk) begin
    logic [15:0] b;
    int n;
    exp_t e;
    if (started) begin
      chk("a_ready", tx_ready_a, line_a.size() <= 1);
      chk("a_busy", is_tx_a, line_a.size() > 0);
      if (line_a.size() > 0) chk("a_tx", tx_a, line_a.pop_front());
      else chk("a_tx_idle", tx_a, 1);
      if (rst) begin
        line_a.delete();
        rxq_a.delete();
      end else if (tx_valid_a && tx_ready_a) begin
        n = frame_bits(tx_data_a, 8, 0, 1, b);
        for (int i = 0; i < n; i++)
          repeat (16) line_a.push_back(b[i]);
        hs_a.push_back(cyc);
        e.d = tx_data_a; e.pe = 0; e.fe = 0;
        if (loop_a) rxq_a.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] b;
    int n;
    exp_t e;
    if (started) begin
      chk("b_ready", tx_ready_b, line_b.size() <= 1);
      if (line_b.size() > 0) chk("b_tx", tx_b, line_b.pop_front());
      else chk("b_tx_idle", tx_b, 1);
      if (rst) begin
        line_b.delete();
        rxq_b.delete();
      end else if (tx_valid_b && tx_ready_b) begin
        n = frame_bits(tx_data_b, 7, 2, 2, b);
        for (int i = 0; i < n; i++)
          repeat (16) line_b.push_back(b[i]);
        hs_b.push_back(cyc);
        e.d = tx_data_b; e.pe = 0; e.fe = 0;
        rxq_b.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started && rx_valid_a) begin
      if (rxq_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_rx_unexpected: got rx_valid data %0h expected none",
                 rx_data_a);
      end else begin
        e = rxq_a.pop_front();
        chk("a_rx_data", rx_data_a, e.d);
        chk("a_rx_perr", pe_a, e.pe);
        chk("a_rx_ferr", fe_a, e.fe);
      end
    end
    if (started && rx_valid_b) begin
      if (rxq_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_rx_unexpected: got rx_valid data %0h expected none",
                 rx_data_b);
      end else begin
        e = rxq_b.pop_front();
        chk("b_rx_data", rx_data_b, e.d);
        chk("b_rx_perr", pe_b, e.pe);
        chk("b_rx_ferr", fe_b, e.fe);
      end
    end
    if (started && rx_valid_c) begin
      if (rxq_c.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL c_rx_unexpected: got rx_valid data %0h expected none",
                 rx_data_c);
      end else begin
        e = rxq_c.pop_front();
        chk("c_rx_data", rx_data_c, e.d);
        chk("c_rx_perr", pe_c, e.pe);
        chk("c_rx_ferr", fe_c, e.fe);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int w, input int d, input logic hold);
    logic ok;
    if (w == 0) begin tx_valid_a = 1'b1; tx_data_a = d[7:0]; end
    else begin tx_valid_b = 1'b1; tx_data_b = d[6:0]; end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (w == 0) ? tx_ready_a : tx_ready_b;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got no tx_ready expected handshake");
    end
    if (!hold) begin
      if (w == 0) tx_valid_a = 1'b0; else tx_valid_b = 1'b0;
    end
  endtask

  task automatic drive(input int w, input logic v, input int clocks);
    if (w == 0) rx_drv_a = v; else rx_drv_c = v;
    step(clocks);
  endtask

  task automatic drive_frame(input int w, input int d, input int par,
                             input logic flip, input logic stop);
    logic [15:0] b;
    int n;
    n = frame_bits(d, 8, par, 1, b);
    if (flip) b[9] = ~b[9];
    b[n-1] = stop;
    for (int i = 0; i < n; i++) drive(w, b[i], 16);
  endtask

  initial begin
    exp_t e;
    int d;
    logic flip;
    n_chk = 0; n_fail = 0; cyc = 0;
    started = 0; rst = 1; loop_a = 1;
    rx_drv_a = 1; rx_drv_c = 1;
    tx_valid_a = 0; tx_data_a = 0;
    tx_valid_b = 0; tx_data_b = 0;
    tx_valid_c = 0; tx_data_c = 0;
    step(3);
    rst = 0;
    started = 1;
    chk("rst_tx", tx_a, 1);
    chk("rst_ready", tx_ready_a, 1);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_rx_data", rx_data_a, 0);
    chk("rst_perr", pe_a, 0);
    chk("rst_ferr", fe_a, 0);
    chk("rst_is_rx", is_rx_a, 0);
    chk("rst_b_tx", tx_b, 1);
    chk("rst_c_data", rx_data_c, 0);

    send(0, 'hA5, 0);
    step(200);
    for (int i = 0; i < 12; i++)
      send(0, $urandom_range(0, 255), (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
    step(200);

    send(0, 'h00, 1);
    send(0, 'hFF, 0);
    chk("b2b_gap", hs_a[hs_a.size()-1] - hs_a[hs_a.size()-2], 160);
    step(200);

    send(1, 'h55, 1);
    send(1, 'h2A, 0);
    chk("7e2_len", hs_b[hs_b.size()-1] - hs_b[hs_b.size()-2], 176);
    for (int i = 0; i < 8; i++)
      send(1, $urandom_range(0, 127), (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
    step(250);

    loop_a = 0;
    drive(0, 0, 5);
    chk("glitch_seen", is_rx_a, 1);
    drive(0, 1, 16);
    chk("glitch_idle", is_rx_a, 0);

    e.d = 'h96; e.pe = 0; e.fe = 1;
    rxq_a.push_back(e);
    drive_frame(0, 'h96, 0, 0, 0);
    drive(0, 0, 640);
    chk("break_one_frame", rxq_a.size(), 0);
    chk("break_idle", is_rx_a, 0);
    drive(0, 1, 32);
    e.d = 'h5A; e.pe = 0; e.fe = 0;
    rxq_a.push_back(e);
    drive_frame(0, 'h5A, 0, 0, 1);
    drive(0, 1, 48);
    chk("rearm_frame", rxq_a.size(), 0);

    for (int i = 0; i < 8; i++) begin
      d = (i < 2) ? 'hC3 : $urandom_range(0, 255);
      flip = (i == 1) ? 1'b1 : ((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      e.d = d[8:0]; e.pe = flip; e.fe = 0;
      rxq_c.push_back(e);
      drive_frame(2, d, 1, flip, 1);
      drive(2, 1, 32);
      chk("c_delivered", rxq_c.size(), 0);
    end

    loop_a = 1;
    send(0, 'h3C, 0);
    step(50);
    rst = 1;
    step(1);
    rst = 0;
    chk("midrst_tx", tx_a, 1);
    chk("midrst_ready", tx_ready_a, 1);
    chk("midrst_busy", is_tx_a, 0);
    chk("midrst_is_rx", is_rx_a, 0);
    step(300);

    chk("end_rxq_a", rxq_a.size(), 0);
    chk("end_rxq_b", rxq_b.size(), 0);
    chk("end_rxq_c", rxq_c.size(), 0);
    chk("end_line_a", line_a.size(), 0);
    chk("end_line_b", line_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
